// File: rtl/umi_merger.sv
// Two-source UMI arbiter: umi0 (writes) has priority, umi1 (read requests) is
// protected from starvation by a bounded wait counter. One registered output slot.
module umi_merger #(
   parameter int unsigned AW      = 64,
   parameter int unsigned UW      = 256,
   parameter int unsigned MAXWAIT = 4
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          umi0_in_valid,
   input  logic [UW-1:0] umi0_in_packet,
   output logic          umi0_in_ready,
   input  logic          umi1_in_valid,
   input  logic [UW-1:0] umi1_in_packet,
   output logic          umi1_in_ready,
   output logic          umi_out_valid,
   output logic [UW-1:0] umi_out_packet,
   input  logic          umi_out_ready
);

   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] MAXW = CW'(MAXWAIT);

   // Elaboration-time guard on parameter ranges
   if (MAXWAIT < 1 || MAXWAIT > 255 || AW < 1) begin : g_bad_param
      $error("umi_merger: illegal parameter value");
   end

   logic          r_out_valid;
   logic [UW-1:0] r_out_packet;
   logic [CW-1:0] r_wait;

   logic          w_load_en;
   logic          w_grant0;
   logic          w_grant1;
   logic          w_acc0;
   logic          w_acc1;
   logic          w_out_valid_nxt;
   logic [UW-1:0] w_out_packet_nxt;
   logic [CW-1:0] w_wait_nxt;

   // Grant, handshake and next-state logic; readies never look at packet data
   always_comb begin
      w_load_en        = ~r_out_valid | umi_out_ready;
      w_grant1         = umi1_in_valid & (~umi0_in_valid | (r_wait == MAXW));
      w_grant0         = umi0_in_valid & ~w_grant1;
      w_acc0           = w_grant0 & w_load_en & nreset;
      w_acc1           = w_grant1 & w_load_en & nreset;
      w_out_valid_nxt  = r_out_valid;
      w_out_packet_nxt = r_out_packet;
      w_wait_nxt       = r_wait;

      if (w_load_en) begin
         w_out_valid_nxt = w_acc0 | w_acc1;
         if (w_acc0) begin
            w_out_packet_nxt = umi0_in_packet;
         end else if (w_acc1) begin
            w_out_packet_nxt = umi1_in_packet;
         end
      end

      // Counter saturates naturally: at MAXW the grant flips to umi1, which clears it
      if (w_acc1 || !umi1_in_valid) begin
         w_wait_nxt = '0;
      end else if (w_acc0) begin
         w_wait_nxt = r_wait + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_out_valid  <= 1'b0;
         r_out_packet <= '0;
         r_wait       <= '0;
      end else begin
         r_out_valid  <= w_out_valid_nxt;
         r_out_packet <= w_out_packet_nxt;
         r_wait       <= w_wait_nxt;
      end
   end

   assign umi0_in_ready  = w_acc0;
   assign umi1_in_ready  = w_acc1;
   assign umi_out_valid  = r_out_valid;
   assign umi_out_packet = r_out_packet;

endmodule

// File: tb/tb_umi_merger.sv
// Directed bench for umi_merger with a packet scoreboard and a reference
// model of the grant/wait-counter behaviour, checked on every falling edge.
module tb_umi_merger;

   localparam int unsigned AW      = 64;
   localparam int unsigned UW      = 256;
   localparam int unsigned MAXWAIT = 4;

   logic          clk = 1'b0;
   logic          nreset;
   logic          umi0_in_valid, umi1_in_valid;
   logic [UW-1:0] umi0_in_packet, umi1_in_packet;
   logic          umi0_in_ready, umi1_in_ready;
   logic          umi_out_valid;
   logic [UW-1:0] umi_out_packet;
   logic          umi_out_ready;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_out  = 0;
   int s0     = 0;
   int s1     = 0;

   logic [UW-1:0] sb[$];
   int            glog[$];
   logic          m_valid = 1'b0;
   int            m_wait  = 0;

   umi_merger #(.AW(AW), .UW(UW), .MAXWAIT(MAXWAIT)) dut (
      .clk            (clk),
      .nreset         (nreset),
      .umi0_in_valid  (umi0_in_valid),
      .umi0_in_packet (umi0_in_packet),
      .umi0_in_ready  (umi0_in_ready),
      .umi1_in_valid  (umi1_in_valid),
      .umi1_in_packet (umi1_in_packet),
      .umi1_in_ready  (umi1_in_ready),
      .umi_out_valid  (umi_out_valid),
      .umi_out_packet (umi_out_packet),
      .umi_out_ready  (umi_out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model and scoreboard, evaluated with inputs settled before the next rising edge
   always @(negedge clk) begin
      logic g0, g1, le, r0, r1;
      logic [UW-1:0] exp_pkt;
      if (!nreset) begin
         check("rst_rdy0", UW'(umi0_in_ready), UW'(0));
         check("rst_rdy1", UW'(umi1_in_ready), UW'(0));
         check("rst_valid", UW'(umi_out_valid), UW'(0));
         check("rst_pkt", umi_out_packet, '0);
         m_valid = 1'b0;
         m_wait  = 0;
         sb.delete();
      end else begin
         check("out_valid", UW'(umi_out_valid), UW'(m_valid));
         if (umi_out_valid && umi_out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", UW'(1), UW'(0));
            end else begin
               exp_pkt = sb.pop_front();
               check("out_pkt", umi_out_packet, exp_pkt);
               n_out++;
            end
         end
         g1 = umi1_in_valid && (!umi0_in_valid || m_wait == int'(MAXWAIT));
         g0 = umi0_in_valid && !g1;
         le = !m_valid || umi_out_ready;
         r0 = g0 && le;
         r1 = g1 && le;
         check("rdy0", UW'(umi0_in_ready), UW'(r0));
         check("rdy1", UW'(umi1_in_ready), UW'(r1));
         if (r0) begin
            sb.push_back(umi0_in_packet);
            glog.push_back(0);
            s0++;
         end
         if (r1) begin
            sb.push_back(umi1_in_packet);
            glog.push_back(1);
            s1++;
         end
         if (le) m_valid = r0 || r1;
         if (r1 || !umi1_in_valid) m_wait = 0;
         else if (r0) m_wait++;
      end
   end

   task automatic drive();
      umi0_in_packet = UW'(32'hA5 + s0);
      umi1_in_packet = UW'(32'h5000 + s1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      logic [UW-1:0] hold;
      int mark;
      nreset        = 1'b0;
      umi0_in_valid = 1'b1;
      umi1_in_valid = 1'b0;
      umi_out_ready = 1'b1;
      drive();
      repeat (2) tick();

      // First packet after reset release is accepted on the first edge
      nreset = 1'b1;
      #1;
      check("first_rdy0", UW'(umi0_in_ready), UW'(1));
      tick();
      check("first_valid", UW'(umi_out_valid), UW'(1));
      check("first_pkt", umi_out_packet, UW'(32'hA5));
      umi0_in_valid = 1'b0;
      repeat (2) tick();

      // umi1 alone: granted every cycle
      mark = glog.size();
      umi1_in_valid = 1'b1;
      repeat (6) tick();
      umi1_in_valid = 1'b0;
      tick();
      check("u1_only_cnt", UW'(glog.size() - mark), UW'(6));
      for (int i = mark; i < glog.size(); i++) check("u1_only_grant", UW'(glog[i]), UW'(1));

      // Both valid: four umi0 grants then one umi1, repeating
      mark = glog.size();
      umi0_in_valid = 1'b1;
      umi1_in_valid = 1'b1;
      repeat (10) tick();
      check("fair_cnt", UW'(glog.size() - mark), UW'(10));
      for (int i = 0; i < 10; i++)
         check("fair_grant", UW'(glog[mark + i]), UW'((i % 5 == 4) ? 1 : 0));

      // Output stall: slot held, no inputs accepted
      umi_out_ready = 1'b0;
      hold = umi_out_packet;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", UW'(umi_out_valid), UW'(1));
         check("stall_pkt", umi_out_packet, hold);
         check("stall_rdy", UW'({umi0_in_ready, umi1_in_ready}), UW'(0));
      end
      umi_out_ready = 1'b1;
      tick();
      check("unstall_valid", UW'(umi_out_valid), UW'(1));
      check("unstall_new", UW'(umi_out_packet !== hold), UW'(1));

      // Asynchronous reset with an unconsumed packet in the slot
      umi_out_ready = 1'b0;
      tick();
      #2;
      nreset = 1'b0;
      #1;
      check("async_valid", UW'(umi_out_valid), UW'(0));
      check("async_pkt", umi_out_packet, '0);
      check("async_rdy", UW'({umi0_in_ready, umi1_in_ready}), UW'(0));
      tick();
      nreset = 1'b1;
      umi1_in_valid = 1'b0;
      umi0_in_valid = 1'b0;
      umi_out_ready = 1'b1;
      tick();

      // umi0 burst of 16: one packet per cycle, no bubbles
      mark = n_out;
      umi0_in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("burst_valid", UW'(umi_out_valid), UW'(1));
      end
      umi0_in_valid = 1'b0;
      repeat (3) tick();
      check("burst_out", UW'(n_out - mark), UW'(16));
      check("sb_empty", UW'(sb.size()), UW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/umi_merger.md
UMI_MERGER -- requirements
Module: umi_merger

Interface
REQ-001 SHALL have parameter AW, default 64, address width.
REQ-002 SHALL have parameter UW, default 256, packet width.
REQ-003 SHALL have parameter MAXWAIT, default 4, legal range 1..255: maximum consecutive umi0 grants while umi1 waits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port umi0_in_valid  input  1  high-priority (write) source valid.
REQ-007 SHALL have port umi0_in_packet  input  UW  high-priority packet.
REQ-008 SHALL have port umi0_in_ready  output  1  umi0 packet accepted this cycle.
REQ-009 SHALL have port umi1_in_valid  input  1  low-priority (read request) source valid.
REQ-010 SHALL have port umi1_in_packet  input  UW  low-priority packet.
REQ-011 SHALL have port umi1_in_ready  output  1  umi1 packet accepted this cycle.
REQ-012 SHALL have port umi_out_valid  output  1  merged output valid, registered.
REQ-013 SHALL have port umi_out_packet  output  UW  merged packet, registered.
REQ-014 SHALL have port umi_out_ready  input  1  downstream accepts the output.

Function
REQ-015 SHALL transfer on any port only when valid and ready are both high in the same cycle.
REQ-016 SHALL hold one output register (packet plus valid flag); load enable = ~umi_out_valid | umi_out_ready.
REQ-017 SHALL keep umi_out_valid and umi_out_packet stable while umi_out_valid=1 and umi_out_ready=0.
REQ-018 SHALL grant umi0 when umi0_in_valid=1, except when the starvation override applies.
REQ-019 SHALL apply the starvation override when umi1_in_valid=1 and wait counter == MAXWAIT; umi1 is then granted.
REQ-020 SHALL grant umi1 when umi1_in_valid=1 and umi0_in_valid=0.
REQ-021 SHALL drive umiN_in_ready = grantN & load enable; at most one in_ready high per cycle.
REQ-022 SHALL compute in_ready combinationally from the valids, counter and umi_out_ready; it SHALL NOT depend on the packet contents.
REQ-023 SHALL load the granted packet into the output register on an accepted input transfer, with umi_out_valid=1 the next cycle (latency 1).
REQ-024 SHALL clear umi_out_valid after an output transfer if no input transfer happens in the same cycle.
REQ-025 SHALL load a new packet on a simultaneous output drain and input accept, keeping umi_out_valid=1 (back-to-back, 1 packet/cycle).
REQ-026 SHALL use an 8-bit wait counter that increments only on an accepted umi0 transfer while umi1_in_valid=1.
REQ-027 SHALL clear the wait counter on an accepted umi1 transfer, and whenever umi1_in_valid=0.
REQ-028 SHALL hold the counter unchanged when no transfer occurs; it never exceeds MAXWAIT.
REQ-029 SHALL pass packets unmodified; no field decoding, since routing was decided upstream.
REQ-030 SHALL NOT drop or duplicate packets; the output order equals the grant order.

Reset
REQ-031 SHALL, on nreset low, asynchronously set umi_out_valid=0, umi_out_packet=0 and wait counter=0.
REQ-032 SHALL drive both in_ready outputs to 0 while nreset is low.
REQ-033 SHALL discard a packet held in the output register when reset is asserted mid-operation; it is not replayed.
REQ-034 SHALL accept a packet in the first clock edge after nreset deasserts if a source is valid.

Verification
REQ-035 SHALL cover: reset, then umi0 valid with packet 0xA5 and umi_out_ready=1 -> umi0_in_ready=1 in cycle 0; umi_out_valid=1 with packet 0xA5 in cycle 1.
REQ-036 SHALL cover: both sources valid continuously, MAXWAIT=4, out_ready=1 -> grant sequence 0,0,0,0,1 repeating; counter 0..4, then 0.
REQ-037 SHALL cover: output full, umi_out_ready=0 for 3 cycles, both sources valid -> both in_ready=0 and output stable; 1 cycle after ready rises, the next packet appears.
REQ-038 SHALL cover: umi0 only, 16 packets, out_ready=1 -> 16 packets out in order, 1 per cycle, no bubbles.
REQ-039 SHALL cover: umi1 only -> umi1 granted every cycle and counter stays 0.
REQ-040 SHALL cover: nreset pulsed low while umi_out_valid=1 with an unconsumed packet -> umi_out_valid=0 and packet=0 immediately, without a clock edge.
